// File: rtl/zigzag_serializer64x8bit.sv
// Zigzag coefficient serializer: captures a 64-coefficient block and streams it out
// one coefficient per transfer, with a one-block pending buffer for gapless back-to-back.
//
// state  | meaning
// IDLE   | no block active, coef_valid low, waiting for a load
// STREAM | presenting active[index], advancing on each valid/ready transfer
module zigzag_serializer64x8bit #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load_enable,
    input  logic [DATA_WIDTH*DEPTH-1:0]   zigzag_pix_in,
    output logic                          load_ready,
    output logic [DATA_WIDTH-1:0]         coef_out,
    output logic                          coef_valid,
    input  logic                          coef_ready,
    output logic [$clog2(DEPTH)-1:0]      coef_index,
    output logic                          coef_last,
    output logic                          busy,
    output logic                          load_overflow
);

    localparam int TOTAL = DATA_WIDTH * DEPTH;
    localparam int IW    = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     index_q, index_d;
    logic [TOTAL-1:0]  active_q, active_d;
    logic [TOTAL-1:0]  pending_q, pending_d;
    logic              pending_full_q, pending_full_d;
    logic              overflow_q, overflow_d;
    logic              load_ok;
    logic              stream;
    logic [DATA_WIDTH-1:0] coef_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            index_q        <= '0;
            pending_full_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            pending_full_q <= pending_full_d;
            overflow_q     <= overflow_d;
        end
    end

    // Data buffers carry no reset; the output gating below hides stale contents.
    always_ff @(posedge clock) begin
        active_q  <= active_d;
        pending_q <= pending_d;
    end

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        overflow_d     = overflow_q;
        load_ok        = load_enable && !pending_full_q;

        if (load_enable && pending_full_q) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    active_d = zigzag_pix_in;
                    index_d  = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (coef_ready && (index_q == LAST_IDX)) begin
                    index_d = '0;
                    if (pending_full_q) begin
                        active_d       = pending_q;
                        pending_full_d = 1'b0;
                    end else if (load_ok) begin
                        active_d = zigzag_pix_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (coef_ready) begin
                        index_d = index_q + IW'(1);
                    end
                    if (load_ok) begin
                        pending_d      = zigzag_pix_in;
                        pending_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Element k sits at the top of the bus for k=0 (DC first).
    always_comb begin
        coef_sel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (index_q == IW'(k)) begin
                coef_sel = active_q[TOTAL-1-DATA_WIDTH*k -: DATA_WIDTH];
            end
        end
    end

    assign stream        = (state_q == STREAM);
    assign coef_valid    = stream;
    assign coef_out      = stream ? coef_sel : '0;
    assign coef_index    = index_q;
    assign coef_last     = stream && (index_q == LAST_IDX);
    assign busy          = stream || pending_full_q;
    assign load_ready    = !pending_full_q;
    assign load_overflow = overflow_q;

endmodule

// File: tb/tb_zigzag_serializer64x8bit.sv
// Directed self-checking bench for zigzag_serializer64x8bit.
module tb_zigzag_serializer64x8bit;

    logic         clock;
    logic         reset_n;
    logic         load_enable;
    logic [511:0] zigzag_pix_in;
    logic         load_ready;
    logic [7:0]   coef_out;
    logic         coef_valid;
    logic         coef_ready;
    logic [5:0]   coef_index;
    logic         coef_last;
    logic         busy;
    logic         load_overflow;

    int checks   = 0;
    int failures = 0;

    zigzag_serializer64x8bit #(.DATA_WIDTH(8), .DEPTH(64)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .load_enable   (load_enable),
        .zigzag_pix_in (zigzag_pix_in),
        .load_ready    (load_ready),
        .coef_out      (coef_out),
        .coef_valid    (coef_valid),
        .coef_ready    (coef_ready),
        .coef_index    (coef_index),
        .coef_last     (coef_last),
        .busy          (busy),
        .load_overflow (load_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [511:0] make_inc();
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[511-8*k -: 8] = 8'(k + 1);
        return b;
    endfunction

    function automatic logic [511:0] make_dec();
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[511-8*k -: 8] = 8'(255 - k);
        return b;
    endfunction

    function automatic logic [511:0] make_fill(input logic [7:0] v);
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[511-8*k -: 8] = v;
        return b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (coef_valid !== 1'b0 || coef_out !== 8'h00 || coef_index !== 6'd0 ||
            coef_last !== 1'b0 || busy !== 1'b0 || load_overflow !== 1'b0 ||
            load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid=%b out=%h idx=%0d last=%b busy=%b ovf=%b lrdy=%b, required 0 00 0 0 0 0 1",
                     tag, coef_valid, coef_out, coef_index, coef_last, busy, load_overflow, load_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_state");
        reset_n = 1'b1;
        tick();
        check_reset_outputs("idle_after_release");
    endtask

    task automatic test_single();
        int n = 0;
        coef_ready    = 1'b1;
        load_enable   = 1'b1;
        zigzag_pix_in = make_inc();
        tick();
        load_enable = 1'b0;
        checks++;
        if (coef_valid !== 1'b1 || coef_index !== 6'd0) begin
            failures++;
            $display("FAIL single_latency: valid=%b idx=%0d, required valid=1 idx=0", coef_valid, coef_index);
        end
        for (int cyc = 0; cyc < 80 && n < 64; cyc++) begin
            checks++;
            if (coef_valid !== 1'b1 || coef_out !== 8'(n + 1) || coef_index !== 6'(n) ||
                coef_last !== (n == 63)) begin
                failures++;
                $display("FAIL single_elem%0d: valid=%b out=%0d idx=%0d last=%b, required 1 %0d %0d %b",
                         n, coef_valid, coef_out, coef_index, coef_last, n + 1, n, (n == 63));
            end
            n++;
            tick();
        end
        checks++;
        if (n !== 64 || coef_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_end: count=%0d valid=%b busy=%b, required 64 0 0", n, coef_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit stall = 1'b0;
        logic [7:0] h_out;
        logic [5:0] h_idx;
        logic       h_last;
        h_out = '0; h_idx = '0; h_last = 1'b0;
        load_enable   = 1'b1;
        zigzag_pix_in = make_inc();
        coef_ready    = 1'b0;
        tick();
        load_enable = 1'b0;
        for (int cyc = 0; cyc < 600 && n < 64; cyc++) begin
            coef_ready = 1'($urandom_range(0, 1));
            if (coef_valid) begin
                if (stall) begin
                    checks++;
                    if (coef_out !== h_out || coef_index !== h_idx || coef_last !== h_last) begin
                        failures++;
                        $display("FAIL bp_stable: out=%0d idx=%0d last=%b, required %0d %0d %b",
                                 coef_out, coef_index, coef_last, h_out, h_idx, h_last);
                    end
                end
                checks++;
                if (coef_out !== 8'(n + 1) || coef_index !== 6'(n) || coef_last !== (n == 63)) begin
                    failures++;
                    $display("FAIL bp_elem%0d: out=%0d idx=%0d last=%b, required %0d %0d %b",
                             n, coef_out, coef_index, coef_last, n + 1, n, (n == 63));
                end
                h_out = coef_out; h_idx = coef_index; h_last = coef_last;
                stall = !coef_ready;
                if (coef_ready) n++;
            end else begin
                checks++;
                failures++;
                $display("FAIL bp_gap: valid=0 at element %0d, required 1", n);
                stall = 1'b0;
            end
            tick();
        end
        coef_ready = 1'b1;
        checks++;
        if (n !== 64 || coef_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end: count=%0d valid=%b, required 64 0", n, coef_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        coef_ready    = 1'b1;
        load_enable   = 1'b1;
        zigzag_pix_in = make_fill(8'hAA);
        tick();
        for (int c = 1; c < 200 && n < 128; c++) begin
            load_enable   = (c == 10);
            zigzag_pix_in = make_fill(8'h55);
            if (c == 11) begin
                checks++;
                if (load_ready !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_pending: load_ready=%b busy=%b, required 0 1", load_ready, busy);
                end
            end
            if (n == 64) begin
                checks++;
                if (load_ready !== 1'b1 || coef_index !== 6'd0) begin
                    failures++;
                    $display("FAIL b2b_handover: load_ready=%b idx=%0d, required 1 0", load_ready, coef_index);
                end
            end
            checks++;
            if (coef_valid !== 1'b1 || coef_out !== ((n < 64) ? 8'hAA : 8'h55) || coef_index !== 6'(n % 64)) begin
                failures++;
                $display("FAIL b2b_elem%0d: valid=%b out=%h idx=%0d, required 1 %h %0d",
                         n, coef_valid, coef_out, coef_index, (n < 64) ? 8'hAA : 8'h55, n % 64);
            end
            n++;
            tick();
        end
        load_enable = 1'b0;
        checks++;
        if (n !== 128 || coef_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: count=%0d valid=%b busy=%b, required 128 0 0", n, coef_valid, busy);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        int seen_c = 0;
        coef_ready    = 1'b1;
        load_enable   = 1'b1;
        zigzag_pix_in = make_fill(8'hAA);
        tick();
        for (int c = 1; c < 200 && n < 128; c++) begin
            load_enable   = (c == 5) || (c == 10);
            zigzag_pix_in = (c == 10) ? make_fill(8'h11) : make_fill(8'h55);
            if (c == 11) begin
                checks++;
                if (load_overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_set: load_overflow=%b, required 1", load_overflow);
                end
            end
            if (coef_valid && coef_out == 8'h11) seen_c++;
            checks++;
            if (coef_valid !== 1'b1 || coef_out !== ((n < 64) ? 8'hAA : 8'h55)) begin
                failures++;
                $display("FAIL ovf_elem%0d: valid=%b out=%h, required 1 %h",
                         n, coef_valid, coef_out, (n < 64) ? 8'hAA : 8'h55);
            end
            n++;
            tick();
        end
        load_enable = 1'b0;
        tick();
        checks++;
        if (n !== 128 || seen_c !== 0 || load_overflow !== 1'b1 || coef_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_end: count=%0d c_seen=%0d ovf=%b valid=%b, required 128 0 1 0",
                     n, seen_c, load_overflow, coef_valid);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_outputs("ovf_cleared_by_reset");
    endtask

    task automatic test_simultaneous();
        int n = 0;
        logic [7:0] exp;
        coef_ready    = 1'b1;
        load_enable   = 1'b1;
        zigzag_pix_in = make_inc();
        tick();
        for (int c = 0; c < 200 && n < 128; c++) begin
            load_enable   = (n == 63);
            zigzag_pix_in = make_dec();
            exp = (n < 64) ? 8'(n + 1) : 8'(255 - (n - 64));
            if (n == 64) begin
                checks++;
                if (coef_valid !== 1'b1 || coef_index !== 6'd0 || coef_out !== 8'd255 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL simul_first: valid=%b idx=%0d out=%0d busy=%b, required 1 0 255 1",
                             coef_valid, coef_index, coef_out, busy);
                end
            end
            checks++;
            if (coef_valid !== 1'b1 || coef_out !== exp || coef_index !== 6'(n % 64)) begin
                failures++;
                $display("FAIL simul_elem%0d: valid=%b out=%0d idx=%0d, required 1 %0d %0d",
                         n, coef_valid, coef_out, coef_index, exp, n % 64);
            end
            n++;
            tick();
        end
        load_enable = 1'b0;
        checks++;
        if (n !== 128 || coef_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_end: count=%0d valid=%b, required 128 0", n, coef_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        int late = 0;
        coef_ready    = 1'b1;
        load_enable   = 1'b1;
        zigzag_pix_in = make_inc();
        tick();
        load_enable = 1'b0;
        for (int c = 0; c < 40 && n < 20; c++) begin
            n++;
            tick();
        end
        checks++;
        if (coef_index !== 6'd20 || coef_out !== 8'd21) begin
            failures++;
            $display("FAIL rst_mid_pre: idx=%0d out=%0d, required 20 21", coef_index, coef_out);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_async");
        tick();
        check_reset_outputs("rst_mid_held");
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (coef_valid !== 1'b0) late++;
        end
        checks++;
        if (late !== 0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_after: valid_cycles=%0d busy=%b lrdy=%b, required 0 0 1", late, busy, load_ready);
        end
        load_enable   = 1'b1;
        zigzag_pix_in = make_dec();
        tick();
        load_enable = 1'b0;
        checks++;
        if (coef_valid !== 1'b1 || coef_index !== 6'd0 || coef_out !== 8'd255) begin
            failures++;
            $display("FAIL rst_mid_reload: valid=%b idx=%0d out=%0d, required 1 0 255", coef_valid, coef_index, coef_out);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n       = 1'b0;
        load_enable   = 1'b0;
        zigzag_pix_in = '0;
        coef_ready    = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
